// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a fixed 3x3 output-stationary systolic array: operand buffers, clear, feed, wait, capture, drain.
// Latency: start at edge t -> CLEAR t+1, FEED t+2..t+4, WAIT t+5..t+4+PIPE_LAT, first result beat the cycle after.
// Backpressure: result beats hold row/data stable until res_ready; loads are refused (load_ready=0) while busy.
module systolic_seq_ctrl #(
    parameter int DATA_SIZE = 8,
    parameter int PIPE_LAT  = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic                       load_sel,
    input  logic [1:0]                 load_idx,
    input  logic [3*DATA_SIZE-1:0]     load_data,
    input  logic                       start,
    output logic                       ready,
    output logic                       busy,
    output logic                       done,
    output logic                       arr_clear,
    output logic [3*DATA_SIZE-1:0]     arr_a,
    output logic [3*DATA_SIZE-1:0]     arr_b,
    input  logic [9*2*DATA_SIZE-1:0]   arr_c,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [1:0]                 res_row,
    output logic [3*2*DATA_SIZE-1:0]   res_data
);

    localparam int DW  = DATA_SIZE;
    localparam int RW  = 2 * DATA_SIZE;
    localparam int WCW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t           state;
    logic [3*DW-1:0]  a_buf [3];   // a_buf[i] = row i of A, element k at k*DW
    logic [3*DW-1:0]  b_buf [3];   // b_buf[j] = column j of B, element k at k*DW
    logic [5:0]       loaded;      // bits 0..2 A rows, bits 3..5 B columns
    logic [1:0]       k;
    logic [WCW-1:0]   wcnt;
    logic [9*RW-1:0]  cap;

    logic             load_wr;
    logic [2:0]       load_slot;
    logic [1:0]       feed_k;
    logic [3*DW-1:0]  feed_a;
    logic [3*DW-1:0]  feed_b;

    assign busy       = (state != S_IDLE);
    assign load_ready = !busy;
    assign ready      = (state == S_IDLE) && (&loaded);
    assign arr_clear  = reset || (state == S_CLEAR);
    assign done       = !reset && (state == S_DRAIN) && res_valid && res_ready && (res_row == 2'd2);

    assign load_wr    = load_valid && load_ready && (load_idx != 2'd3);
    assign load_slot  = {1'b0, load_idx} + (load_sel ? 3'd3 : 3'd0);

    // Lane values for the feed cycle about to start: column k of A, row k of B.
    always_comb begin
        feed_k = (state == S_FEED) ? (k + 2'd1) : 2'd0;
        feed_a = '0;
        feed_b = '0;
        for (int i = 0; i < 3; i++) begin
            feed_a[i*DW +: DW] = a_buf[i][feed_k*DW +: DW];
            feed_b[i*DW +: DW] = b_buf[i][feed_k*DW +: DW];
        end
    end

    // Operand buffers and loaded mask; both survive across operations.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                a_buf[i] <= '0;
                b_buf[i] <= '0;
            end
            loaded <= '0;
        end else if (load_wr) begin
            if (load_sel) b_buf[load_idx] <= load_data;
            else          a_buf[load_idx] <= load_data;
            loaded[load_slot] <= 1'b1;
        end
    end

    // Sequencer FSM with registered lane drive, capture and result handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            k         <= '0;
            wcnt      <= '0;
            cap       <= '0;
            arr_a     <= '0;
            arr_b     <= '0;
            res_valid <= 1'b0;
            res_row   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && (&loaded)) state <= S_CLEAR;
                end
                S_CLEAR: begin
                    state <= S_FEED;
                    k     <= 2'd0;
                    arr_a <= feed_a;
                    arr_b <= feed_b;
                end
                S_FEED: begin
                    if (k == 2'd2) begin
                        state <= S_WAIT;
                        wcnt  <= '0;
                        arr_a <= '0;
                        arr_b <= '0;
                    end else begin
                        k     <= k + 2'd1;
                        arr_a <= feed_a;
                        arr_b <= feed_b;
                    end
                end
                S_WAIT: begin
                    if (wcnt == WCW'(PIPE_LAT - 1)) begin
                        cap       <= arr_c;
                        state     <= S_DRAIN;
                        res_valid <= 1'b1;
                        res_row   <= 2'd0;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (res_ready) begin
                        if (res_row == 2'd2) begin
                            state     <= S_IDLE;
                            res_valid <= 1'b0;
                            res_row   <= 2'd0;
                        end else begin
                            res_row <= res_row + 2'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Current beat is a straight row slice of the capture register.
    always_comb begin
        case (res_row)
            2'd0:    res_data = cap[0      +: 3*RW];
            2'd1:    res_data = cap[3*RW   +: 3*RW];
            default: res_data = cap[6*RW   +: 3*RW];
        endcase
    end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
`timescale 1ns/1ps
module tb_systolic_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic        load_sel;
    logic [1:0]  load_idx;
    logic [23:0] load_data;
    logic        start;
    logic        ready;
    logic        busy;
    logic        done;
    logic        arr_clear;
    logic [23:0] arr_a;
    logic [23:0] arr_b;
    logic [143:0] arr_c;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_row;
    logic [47:0] res_data;

    int checks = 0;
    int errors = 0;

    int a_m [3][3];
    int b_m [3][3];
    logic [47:0] exp_rows [3];

    logic [15:0] acc [9];

    always #5 clk = ~clk;

    systolic_seq_ctrl #(.DATA_SIZE(8), .PIPE_LAT(5)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready), .load_sel(load_sel),
        .load_idx(load_idx), .load_data(load_data),
        .start(start), .ready(ready), .busy(busy), .done(done),
        .arr_clear(arr_clear), .arr_a(arr_a), .arr_b(arr_b), .arr_c(arr_c),
        .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row), .res_data(res_data)
    );

    // Behavioural 3x3 output-stationary array fed by the unskewed lanes.
    always @(posedge clk) begin
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                if (arr_clear) acc[r*3+c] <= '0;
                else acc[r*3+c] <= acc[r*3+c] + ({8'd0, arr_a[r*8 +: 8]} * {8'd0, arr_b[c*8 +: 8]});
    end

    always_comb begin
        arr_c = '0;
        for (int i = 0; i < 9; i++) arr_c[i*16 +: 16] = acc[i];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pack3(input int e0, input int e1, input int e2);
        return {8'(e2), 8'(e1), 8'(e0)};
    endfunction

    function automatic logic [47:0] row3(input int c0, input int c1, input int c2);
        return {16'(c2), 16'(c1), 16'(c0)};
    endfunction

    task automatic load(input logic sel, input logic [1:0] idx, input int e0, input int e1, input int e2);
        @(negedge clk);
        load_valid = 1'b1;
        load_sel   = sel;
        load_idx   = idx;
        load_data  = pack3(e0, e1, e2);
        @(negedge clk);
        load_valid = 1'b0;
        if (idx != 2'd3) begin
            if (sel) begin
                b_m[0][idx] = e0; b_m[1][idx] = e1; b_m[2][idx] = e2;
            end else begin
                a_m[idx][0] = e0; a_m[idx][1] = e1; a_m[idx][2] = e2;
            end
        end
    endtask

    // A = M = [[1,2,3],[4,5,6],[7,8,9]]
    task automatic load_a_m();
        load(1'b0, 2'd0, 1, 2, 3);
        load(1'b0, 2'd1, 4, 5, 6);
        load(1'b0, 2'd2, 7, 8, 9);
    endtask

    // B = M, given as columns
    task automatic load_b_m();
        load(1'b1, 2'd0, 1, 4, 7);
        load(1'b1, 2'd1, 2, 5, 8);
        load(1'b1, 2'd2, 3, 6, 9);
    endtask

    task automatic set_exp_square();
        exp_rows[0] = row3(30, 36, 42);
        exp_rows[1] = row3(66, 81, 96);
        exp_rows[2] = row3(102, 126, 150);
    endtask

    // Issue start and follow the operation cycle by cycle; c counts cycles after the start edge.
    task automatic run_op(input bit toggle, input int exp_done_c, input bit chain);
        int beat;
        int hold;
        int first_c;
        int done_c;
        logic [23:0] ea;
        logic [23:0] eb;
        beat = 0; hold = 0; first_c = 0; done_c = 0;
        @(negedge clk);
        chk("ready_before_start", ready, 1);
        start = 1'b1;
        for (int c = 1; c <= 60 && beat < 3; c++) begin
            @(negedge clk);
            res_ready = toggle ? (hold == 2) : 1'b1;
            if (chain && res_valid && beat == 2 && res_ready) start = 1'b1;
            #1;
            if (c == 1) begin
                start = 1'b0;
                chk("clear_pulse", arr_clear, 1);
                chk("load_ready_busy", load_ready, 0);
            end
            if (c >= 2 && c <= 4) begin
                for (int i = 0; i < 3; i++) begin
                    ea[i*8 +: 8] = 8'(a_m[i][c-2]);
                    eb[i*8 +: 8] = 8'(b_m[c-2][i]);
                end
                chk("feed_a", arr_a, ea);
                chk("feed_b", arr_b, eb);
            end
            if (c == 5) chk("wait_a_zero", arr_a, 0);
            if (res_valid) begin
                if (first_c == 0) first_c = c;
                chk("res_row", res_row, beat);
                chk("res_data", res_data, exp_rows[beat]);
                if (res_ready) begin
                    chk("done_on_beat", done, beat == 2);
                    if (beat == 2) done_c = c;
                    beat++;
                    hold = 0;
                end else begin
                    chk("done_while_held", done, 0);
                    hold++;
                end
            end else begin
                chk("done_idle", done, 0);
            end
        end
        chk("first_valid_cycle", first_c, 10);
        chk("done_cycle", done_c, exp_done_c);
        chk("beat_count", beat, 3);
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        chk("post_busy", busy, 0);
        chk("post_valid", res_valid, 0);
        chk("post_done", done, 0);
    endtask

    initial begin
        reset = 1'b1; load_valid = 1'b0; load_sel = 1'b0; load_idx = 2'd0;
        load_data = '0; start = 1'b0; res_ready = 1'b0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                a_m[r][c] = 0; b_m[r][c] = 0;
            end

        // Reset values
        @(negedge clk);
        chk("clear_in_reset", arr_clear, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_load_ready", load_ready, 1);
        chk("rst_ready", ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_row", res_row, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_arr_a", arr_a, 0);
        chk("rst_arr_b", arr_b, 0);
        chk("rst_arr_clear", arr_clear, 0);

        // Five rows loaded plus an ignored idx=3 write: start must be ignored
        load_a_m();
        load(1'b1, 2'd0, 1, 0, 0);
        load(1'b1, 2'd1, 0, 1, 0);
        load(1'b1, 2'd3, 9, 9, 9);
        #1;
        chk("ready_5_rows", ready, 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("ignored_start_busy", busy, 0);
        chk("ignored_start_clear", arr_clear, 0);
        load(1'b1, 2'd2, 0, 0, 1);
        #1;
        chk("ready_6_rows", ready, 1);

        // C = A * I = A
        exp_rows[0] = row3(1, 2, 3);
        exp_rows[1] = row3(4, 5, 6);
        exp_rows[2] = row3(7, 8, 9);
        run_op(1'b0, 12, 1'b0);

        // A = B = M, stalled drain, start held on the done cycle
        load_b_m();
        set_exp_square();
        run_op(1'b1, 18, 1'b1);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("chain_clear", arr_clear, 1);
        chk("chain_busy", busy, 1);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("abort_feed_k1", arr_a, pack3(2, 5, 8));
        reset = 1'b1;
        #1;
        chk("abort_no_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_ready", ready, 0);
        chk("abort_valid", res_valid, 0);
        chk("abort_done", done, 0);
        chk("abort_arr_a", arr_a, 0);
        chk("abort_load_ready", load_ready, 1);

        // Reload and rerun the square case
        load_a_m();
        load_b_m();
        set_exp_square();
        run_op(1'b0, 12, 1'b0);

        // All 255: 3*255*255 = 195075 wraps to 64003
        for (int i = 0; i < 3; i++) begin
            load(1'b0, 2'(i), 255, 255, 255);
            load(1'b1, 2'(i), 255, 255, 255);
        end
        for (int i = 0; i < 3; i++) exp_rows[i] = row3(64003, 64003, 64003);
        run_op(1'b0, 12, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
